// File: rtl/adxl_frame_sched.sv
// rtl/adxl_frame_sched.sv - ADXL345 link sequencer: SPI config/sample reads, UART frame out
// Frame on UART: SYNC, DATAX0..DATAZ1, 8-bit wrap-around sum of the six data bytes.
module adxl_frame_sched #(
  parameter int unsigned CLKS_PER_SAMPLE = 500000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hCC,
  parameter logic [15:0] CFG0_WORD       = 16'h2D08,
  parameter logic [15:0] CFG1_WORD       = 16'h310B,
  parameter logic [5:0]  DATA_BASE       = 6'h32
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_enable,
  output logic        o_spi_go,
  output logic        o_spi_read,
  output logic [15:0] o_spi_word,
  input  logic        i_spi_busy,
  input  logic [7:0]  i_spi_rdata,
  output logic        o_uart_start,
  output logic [7:0]  o_uart_data,
  input  logic        i_uart_busy,
  output logic        o_frame_done,
  output logic        o_overrun,
  output logic        o_cfg_done
);

  localparam int unsigned TW = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_SAMPLE - 1);

  typedef enum logic [3:0] {
    CFG0, CFG0_W, CFG1, CFG1_W, IDLE, RD, RD_W,
    TX_SYNC, TX_SYNC_W, TX_D, TX_D_W, TX_SUM, TX_SUM_W
  } state_t;

  state_t      state_q;
  logic [TW-1:0] timer_q, timer_d;
  logic        tick;
  logic [2:0]  idx_q;
  logic [7:0]  data_q [6];
  logic [7:0]  sum_q;
  logic        seen_q;
  logic        spi_go_q, spi_read_q, uart_start_q, frame_done_q, overrun_q, cfg_done_q;
  logic [15:0] spi_word_q;
  logic [7:0]  uart_data_q;
  logic        spi_done, uart_done;

  always_comb begin
    tick    = (timer_q == TIMER_LAST);
    timer_d = tick ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) timer_q <= '0;
    else         timer_q <= timer_d;
  end

  // seen_q is shared: SPI and UART phases never overlap
  assign spi_done  = seen_q & ~i_spi_busy;
  assign uart_done = seen_q & ~i_uart_busy;

  function automatic logic [15:0] rd_word(input logic [2:0] k);
    logic [5:0] a;
    a = DATA_BASE + {3'b000, k};
    return {2'b10, a, 8'h00};
  endfunction

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= CFG0;
      idx_q        <= '0;
      sum_q        <= '0;
      seen_q       <= 1'b0;
      spi_go_q     <= 1'b0;
      spi_read_q   <= 1'b0;
      spi_word_q   <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      cfg_done_q   <= 1'b0;
      for (int i = 0; i < 6; i++) data_q[i] <= '0;
    end else begin
      spi_go_q     <= 1'b0;
      uart_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        CFG0: if (!i_spi_busy) begin
          spi_go_q   <= 1'b1;
          spi_read_q <= 1'b0;
          spi_word_q <= CFG0_WORD;
          seen_q     <= 1'b0;
          state_q    <= CFG0_W;
        end
        CFG0_W: begin
          if (i_spi_busy) seen_q <= 1'b1;
          if (spi_done) state_q <= CFG1;
        end
        CFG1: if (!i_spi_busy) begin
          spi_go_q   <= 1'b1;
          spi_read_q <= 1'b0;
          spi_word_q <= CFG1_WORD;
          seen_q     <= 1'b0;
          state_q    <= CFG1_W;
        end
        CFG1_W: begin
          if (i_spi_busy) seen_q <= 1'b1;
          if (spi_done) begin
            cfg_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        // first read goes out straight from IDLE so the tick-to-go latency is one cycle
        IDLE: if (tick && i_enable) begin
          idx_q <= '0;
          if (!i_spi_busy) begin
            spi_go_q   <= 1'b1;
            spi_read_q <= 1'b1;
            spi_word_q <= rd_word(3'd0);
            seen_q     <= 1'b0;
            state_q    <= RD_W;
          end else begin
            state_q <= RD;
          end
        end
        RD: if (!i_spi_busy) begin
          spi_go_q   <= 1'b1;
          spi_read_q <= 1'b1;
          spi_word_q <= rd_word(idx_q);
          seen_q     <= 1'b0;
          state_q    <= RD_W;
        end
        RD_W: begin
          if (i_spi_busy) seen_q <= 1'b1;
          if (spi_done) begin
            data_q[idx_q] <= i_spi_rdata;
            sum_q         <= sum_q + i_spi_rdata;
            if (idx_q == 3'd5) begin
              idx_q   <= '0;
              state_q <= TX_SYNC;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= RD;
            end
          end
        end
        TX_SYNC: if (!i_uart_busy) begin
          uart_start_q <= 1'b1;
          uart_data_q  <= SYNC_BYTE;
          seen_q       <= 1'b0;
          state_q      <= TX_SYNC_W;
        end
        TX_SYNC_W: begin
          if (i_uart_busy) seen_q <= 1'b1;
          if (uart_done) state_q <= TX_D;
        end
        TX_D: if (!i_uart_busy) begin
          uart_start_q <= 1'b1;
          uart_data_q  <= data_q[idx_q];
          seen_q       <= 1'b0;
          state_q      <= TX_D_W;
        end
        TX_D_W: begin
          if (i_uart_busy) seen_q <= 1'b1;
          if (uart_done) begin
            if (idx_q == 3'd5) begin
              state_q <= TX_SUM;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= TX_D;
            end
          end
        end
        TX_SUM: if (!i_uart_busy) begin
          uart_start_q <= 1'b1;
          uart_data_q  <= sum_q;
          seen_q       <= 1'b0;
          state_q      <= TX_SUM_W;
        end
        TX_SUM_W: begin
          if (i_uart_busy) seen_q <= 1'b1;
          if (uart_done) begin
            frame_done_q <= 1'b1;
            sum_q        <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= CFG0;
      endcase
    end
  end

  assign o_spi_go     = spi_go_q;
  assign o_spi_read   = spi_read_q;
  assign o_spi_word   = spi_word_q;
  assign o_uart_start = uart_start_q;
  assign o_uart_data  = uart_data_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;
  assign o_cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_adxl_frame_sched.sv
// tb/tb_adxl_frame_sched.sv - bench for adxl_frame_sched with SPI/UART BFMs and scoreboard
module tb_adxl_frame_sched;

  localparam int N = 200;

  logic clk, rst, enable;
  logic spi_go, spi_read, spi_busy, uart_start, uart_busy, frame_done, overrun, cfg_done;
  logic [15:0] spi_word;
  logic [7:0]  spi_rdata, uart_data;

  int n_cmp = 0, n_err = 0;
  int spi_cnt = 0, uart_cnt = 0, fd_cnt = 0, tcount;
  int spi_busy_cyc = 4, uart_busy_cyc = 4;

  logic [16:0] exp_spi_q [$];
  logic [7:0]  exp_uart_q [$];
  logic [7:0]  spi_data_q [$];

  typedef struct packed {
    logic [47:0] data;
    logic [7:0]  sum;
  } vec_t;
  vec_t vecs [5];

  adxl_frame_sched #(.CLKS_PER_SAMPLE(N)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_enable(enable),
    .o_spi_go(spi_go), .o_spi_read(spi_read), .o_spi_word(spi_word),
    .i_spi_busy(spi_busy), .i_spi_rdata(spi_rdata),
    .o_uart_start(uart_start), .o_uart_data(uart_data), .i_uart_busy(uart_busy),
    .o_frame_done(frame_done), .o_overrun(overrun), .o_cfg_done(cfg_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) tcount <= 0;
    else     tcount <= (tcount == N - 1) ? 0 : tcount + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input vec_t v);
    logic [7:0] b;
    exp_uart_q.push_back(8'hCC);
    for (int k = 0; k < 6; k++) begin
      b = v.data[47 - 8*k -: 8];
      spi_data_q.push_back(b);
      exp_spi_q.push_back({1'b1, 16'hB200 + 16'(k) * 16'h0100});
      exp_uart_q.push_back(b);
    end
    exp_uart_q.push_back(v.sum);
  endtask

  // SPI slave BFM
  initial begin
    logic [16:0] got;
    logic [15:0] w;
    logic ab;
    spi_busy = 0;
    spi_rdata = 0;
    forever begin
      @(negedge clk);
      if (spi_go) begin
        spi_cnt++;
        got = {spi_read, spi_word};
        w = spi_word;
        check("spi_go_while_busy", {31'b0, spi_busy}, 0);
        if (exp_spi_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spi_unexpected_go: got %h expected none", got);
        end else begin
          check("spi_word", {15'b0, got}, {15'b0, exp_spi_q.pop_front()});
        end
        if (got == 17'h1B200) check("tick_to_first_read", tcount, 0);
        @(posedge clk);
        #1 spi_busy = 1;
        ab = 0;
        for (int i = 0; i < spi_busy_cyc; i++) begin
          @(negedge clk);
          if (rst) ab = 1;
          if (!ab) begin
            check("spi_word_hold", {16'b0, spi_word}, {16'b0, w});
            check("spi_go_in_txn", {31'b0, spi_go}, 0);
          end
          @(posedge clk);
        end
        #1 spi_busy = 0;
        if (got[16] && spi_data_q.size() != 0) spi_rdata = spi_data_q.pop_front();
      end
    end
  end

  // UART tx BFM
  initial begin
    logic [7:0] d;
    logic ab;
    uart_busy = 0;
    forever begin
      @(negedge clk);
      if (uart_start) begin
        uart_cnt++;
        d = uart_data;
        check("uart_start_while_busy", {31'b0, uart_busy}, 0);
        if (exp_uart_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL uart_unexpected_start: got %h expected none", d);
        end else begin
          check("uart_byte", {24'b0, d}, {24'b0, exp_uart_q.pop_front()});
        end
        @(posedge clk);
        #1 uart_busy = 1;
        ab = 0;
        for (int i = 0; i < uart_busy_cyc; i++) begin
          @(negedge clk);
          if (rst) ab = 1;
          if (!ab) begin
            check("uart_data_hold", {24'b0, uart_data}, {24'b0, d});
            check("uart_start_in_txn", {31'b0, uart_start}, 0);
          end
          @(posedge clk);
        end
        #1 uart_busy = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic run_frame(input vec_t v);
    int c0, f0;
    c0 = spi_cnt;
    f0 = fd_cnt;
    push_frame(v);
    enable = 1;
    for (int i = 0; i < 2*N + 20 && spi_cnt == c0; i++) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 1000 && fd_cnt == f0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("frame_done_pulses", fd_cnt, f0 + 1);
    check("scoreboard_drained", exp_spi_q.size() + exp_uart_q.size(), 0);
  endtask

  initial begin
    int c0, f0, u0;
    vecs[0] = '{data: 48'h010203040506, sum: 8'h15};
    vecs[1] = '{data: 48'hFFFFFFFFFF02, sum: 8'hFD};
    vecs[2] = '{data: 48'h102030405060, sum: 8'h50};
    vecs[3] = '{data: 48'hA55A00FF0100, sum: 8'hFF};
    vecs[4] = '{data: 48'h808000000000, sum: 8'h00};

    rst = 1;
    enable = 0;
    exp_spi_q.push_back(17'h02D08);
    exp_spi_q.push_back(17'h0310B);
    repeat (3) @(negedge clk);
    check("reset_outputs", {2'b0, spi_go, spi_read, spi_word, uart_start, uart_data,
                            frame_done, overrun, cfg_done}, 0);
    rst = 0;

    for (int i = 0; i < 200 && !cfg_done; i++) @(negedge clk);
    check("cfg_done", {31'b0, cfg_done}, 1);
    check("cfg_writes", spi_cnt, 2);
    check("cfg_drained", exp_spi_q.size(), 0);

    repeat (2*N + 10) @(negedge clk);
    check("idle_disabled_no_go", spi_cnt, 2);
    check("idle_disabled_no_overrun", {31'b0, overrun}, 0);

    for (int v = 0; v < 4; v++) run_frame(vecs[v]);
    check("no_overrun_short_frames", {31'b0, overrun}, 0);

    // slow UART: frame outlasts the sample period
    uart_busy_cyc = 40;
    f0 = fd_cnt;
    push_frame(vecs[4]);
    push_frame(vecs[0]);
    enable = 1;
    for (int i = 0; i < 3000 && fd_cnt < f0 + 2; i++) @(negedge clk);
    enable = 0;
    check("overrun_frames", fd_cnt, f0 + 2);
    check("overrun_set", {31'b0, overrun}, 1);
    check("overrun_drained", exp_spi_q.size() + exp_uart_q.size(), 0);
    uart_busy_cyc = 4;
    repeat (20) @(negedge clk);

    // enable drops during UART byte 3
    c0 = spi_cnt;
    u0 = uart_cnt;
    f0 = fd_cnt;
    push_frame(vecs[1]);
    enable = 1;
    for (int i = 0; i < 1000 && uart_cnt < u0 + 3; i++) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 500 && fd_cnt == f0; i++) @(negedge clk);
    repeat (2*N + 10) @(negedge clk);
    check("en_low_frame_done", fd_cnt, f0 + 1);
    check("en_low_uart_bytes", uart_cnt, u0 + 8);
    check("en_low_no_more_go", spi_cnt, c0 + 6);
    check("en_low_drained", exp_spi_q.size() + exp_uart_q.size(), 0);
    check("overrun_sticky", {31'b0, overrun}, 1);

    // reset during RD_W
    c0 = spi_cnt;
    push_frame(vecs[2]);
    enable = 1;
    for (int i = 0; i < 2*N + 20 && spi_cnt == c0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1;
    #1 check("mid_reset_outputs", {2'b0, spi_go, spi_read, spi_word, uart_start, uart_data,
                                   frame_done, overrun, cfg_done}, 0);
    exp_spi_q.delete();
    exp_uart_q.delete();
    spi_data_q.delete();
    exp_spi_q.push_back(17'h02D08);
    exp_spi_q.push_back(17'h0310B);
    enable = 0;
    c0 = spi_cnt;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 300 && !cfg_done; i++) @(negedge clk);
    check("recfg_done", {31'b0, cfg_done}, 1);
    check("recfg_writes", spi_cnt, c0 + 2);
    check("recfg_drained", exp_spi_q.size(), 0);
    check("recfg_overrun_clear", {31'b0, overrun}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
